// File: rtl/decode_execute.sv
// Two-cycle FETCH/EXEC sequencer with a 4-bit accumulator ALU, flags and PC strobes.
// Define DECODE_HALT_EN to make opcode F enter a terminal HALT state; otherwise F is a NOP.
module decode_execute (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [3:0]  instruccion,
    input  logic [3:0]  operando,
    input  logic [11:0] pc,
    input  logic [3:0]  data_in,
    output logic        enabled_fetch,
    output logic        enabledCounter,
    output logic        loadCounter,
    output logic [11:0] jump_addr,
    output logic [3:0]  acc,
    output logic [3:0]  data_out,
    output logic        carry,
    output logic        zero,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  acc_q, acc_d;
    logic [3:0]  data_out_q, data_out_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;

    logic [4:0]  sum_ext;
    logic [3:0]  diff;
    logic        no_borrow;
    logic        taken;
    logic        halt_op;
    logic        unused_pc_low;

    // The low PC nibble is replaced by the operand: jumps never leave the page.
    assign jump_addr     = {pc[11:4], operando};
    assign unused_pc_low = ^pc[3:0];

    assign sum_ext   = {1'b0, acc_q} + {1'b0, operando};
    assign diff      = acc_q - operando;
    assign no_borrow = (acc_q >= operando);

`ifdef DECODE_HALT_EN
    assign halt_op = (instruccion == 4'hF);
    assign halted  = (state_q == HALT);
`else
    assign halt_op = 1'b0;
    assign halted  = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        data_out_d     = data_out_q;
        carry_d        = carry_q;
        zero_d         = zero_q;
        enabled_fetch  = 1'b0;
        enabledCounter = 1'b0;
        loadCounter    = 1'b0;
        taken          = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                enabled_fetch = 1'b1;
                state_d       = EXEC;
            end
            EXEC: begin
                state_d = halt_op ? HALT : FETCH;
                case (instruccion)
                    4'h1: begin
                        acc_d  = operando;
                        zero_d = (operando == 4'h0);
                    end
                    4'h2: begin
                        acc_d   = sum_ext[3:0];
                        carry_d = sum_ext[4];
                        zero_d  = (sum_ext[3:0] == 4'h0);
                    end
                    4'h3: begin
                        acc_d   = diff;
                        carry_d = no_borrow;
                        zero_d  = (diff == 4'h0);
                    end
                    4'h4: begin
                        acc_d  = acc_q & operando;
                        zero_d = ((acc_q & operando) == 4'h0);
                    end
                    4'h5: begin
                        acc_d  = acc_q | operando;
                        zero_d = ((acc_q | operando) == 4'h0);
                    end
                    4'h6: begin
                        acc_d  = acc_q ^ operando;
                        zero_d = ((acc_q ^ operando) == 4'h0);
                    end
                    4'h7: begin
                        carry_d = no_borrow;
                        zero_d  = (diff == 4'h0);
                    end
                    4'h8: begin
                        acc_d  = data_in;
                        zero_d = (data_in == 4'h0);
                    end
                    4'h9: data_out_d = acc_q;
                    // Conditional jumps test the flags as they stand before this edge.
                    4'hA: taken = 1'b1;
                    4'hB: taken = carry_q;
                    4'hC: taken = ~carry_q;
                    4'hD: taken = zero_q;
                    4'hE: taken = ~zero_q;
                    default: ;
                endcase
                loadCounter    = taken;
                enabledCounter = ~taken & ~halt_op;
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            acc_q      <= 4'h0;
            data_out_q <= 4'h0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
        end
    end

    assign acc      = acc_q;
    assign data_out = data_out_q;
    assign carry    = carry_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_decode_execute.sv
// Randomized self-checking bench for decode_execute against an instruction-level reference model.
// Honours DECODE_HALT_EN the same way the design does when checking opcode F.
module tb_decode_execute;

`ifdef DECODE_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        run;
    logic [3:0]  instruccion;
    logic [3:0]  operando;
    logic [11:0] pc;
    logic [3:0]  data_in;
    logic        enabled_fetch;
    logic        enabledCounter;
    logic        loadCounter;
    logic [11:0] jump_addr;
    logic [3:0]  acc;
    logic [3:0]  data_out;
    logic        carry;
    logic        zero;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // Architectural reference state, advanced one whole instruction at a time.
    int mAcc   = 0;
    int mOut   = 0;
    int mCarry = 0;
    int mZero  = 0;

    decode_execute dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .instruccion    (instruccion),
        .operando       (operando),
        .pc             (pc),
        .data_in        (data_in),
        .enabled_fetch  (enabled_fetch),
        .enabledCounter (enabledCounter),
        .loadCounter    (loadCounter),
        .jump_addr      (jump_addr),
        .acc            (acc),
        .data_out       (data_out),
        .carry          (carry),
        .zero           (zero),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, ".acc"},   12'(acc),      12'(mAcc));
        checkOutput({tag, ".carry"}, 12'(carry),    12'(mCarry));
        checkOutput({tag, ".zero"},  12'(zero),     12'(mZero));
        checkOutput({tag, ".dout"},  12'(data_out), 12'(mOut));
    endtask

    // Called at a falling edge while the DUT is in FETCH; returns at the falling edge after EXEC.
    task automatic applyStimulus(input logic [3:0] opc, input logic [3:0] opr,
                                 input logic [11:0] pcv, input logic [3:0] din);
        int a, o, r, tk, expInc;
        checkOutput("fetch.en",   12'(enabled_fetch),  12'd1);
        checkOutput("fetch.inc",  12'(enabledCounter), 12'd0);
        checkOutput("fetch.load", 12'(loadCounter),    12'd0);
        instruccion = opc;
        operando    = opr;
        pc          = pcv;
        data_in     = din;
        @(posedge clk);
        @(negedge clk);

        a = mAcc;
        o = int'(opr);
        case (int'(opc))
            10:      tk = 1;
            11:      tk = mCarry;
            12:      tk = 1 - mCarry;
            13:      tk = mZero;
            14:      tk = 1 - mZero;
            default: tk = 0;
        endcase
        expInc = (tk == 0 && !(HALT_EN && opc == 4'hF)) ? 1 : 0;
        checkOutput("exec.en",   12'(enabled_fetch),  12'd0);
        checkOutput("exec.load", 12'(loadCounter),    12'(tk));
        checkOutput("exec.inc",  12'(enabledCounter), 12'(expInc));
        checkOutput("exec.jaddr", jump_addr, 12'((int'(pcv) / 16) * 16 + o));

        case (int'(opc))
            1: begin mAcc = o; mZero = (o == 0); end
            2: begin r = a + o; mCarry = (r > 15); mAcc = r % 16; mZero = (mAcc == 0); end
            3: begin mCarry = (a >= o); mAcc = (a - o + 16) % 16; mZero = (mAcc == 0); end
            4: begin mAcc = a & o; mZero = (mAcc == 0); end
            5: begin mAcc = a | o; mZero = (mAcc == 0); end
            6: begin mAcc = a ^ o; mZero = (mAcc == 0); end
            7: begin mCarry = (a >= o); mZero = (((a - o + 16) % 16) == 0); end
            8: begin mAcc = int'(din); mZero = (mAcc == 0); end
            9: mOut = a;
            default: ;
        endcase

        @(posedge clk);
        @(negedge clk);
        checkRegs("post");
        checkOutput("post.halted", 12'(halted), 12'((HALT_EN && opc == 4'hF) ? 1 : 0));
    endtask

    initial begin
        reset       = 1'b0;
        run         = 1'b0;
        instruccion = 4'h0;
        operando    = 4'h0;
        pc          = 12'h000;
        data_in     = 4'h0;
        repeat (2) @(negedge clk);
        checkOutput("rst.fetch", 12'(enabled_fetch),  12'd0);
        checkOutput("rst.inc",   12'(enabledCounter), 12'd0);
        checkOutput("rst.load",  12'(loadCounter),    12'd0);
        checkOutput("rst.halt",  12'(halted),         12'd0);
        checkRegs("rst");

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idle.fetch", 12'(enabled_fetch), 12'd0);
            checkOutput("idle.inc",   12'(enabledCounter), 12'd0);
        end
        run = 1'b1;
        @(posedge clk);
        @(negedge clk);

        applyStimulus(4'h1, 4'h9, 12'h010, 4'h0);
        applyStimulus(4'h2, 4'h9, 12'h011, 4'h0);
        checkOutput("add99.acc",   12'(acc),   12'h2);
        checkOutput("add99.carry", 12'(carry), 12'h1);
        checkOutput("add99.zero",  12'(zero),  12'h0);

        applyStimulus(4'h1, 4'h5, 12'h121, 4'h0);
        applyStimulus(4'h7, 4'h5, 12'h122, 4'h0);
        checkOutput("cmp.zero",  12'(zero),  12'h1);
        checkOutput("cmp.carry", 12'(carry), 12'h1);
        checkOutput("cmp.acc",   12'(acc),   12'h5);
        applyStimulus(4'hD, 4'hC, 12'h123, 4'h0);

        applyStimulus(4'h1, 4'h2, 12'h200, 4'h0);
        applyStimulus(4'h3, 4'h3, 12'h201, 4'h0);
        checkOutput("sub.acc",   12'(acc),   12'hF);
        checkOutput("sub.carry", 12'(carry), 12'h0);
        applyStimulus(4'hB, 4'h4, 12'h202, 4'h0);

        applyStimulus(4'h8, 4'h0, 12'h300, 4'hA);
        applyStimulus(4'h9, 4'h0, 12'h301, 4'h3);
        checkOutput("io.acc",  12'(acc),      12'hA);
        checkOutput("io.dout", 12'(data_out), 12'hA);
        checkOutput("io.zero", 12'(zero),     12'h0);

        for (int i = 0; i < 200; i++) begin
            applyStimulus(4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)),
                          12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15)));
        end

        // Reset asserted in the middle of an ADD must abandon the write.
        applyStimulus(4'h1, 4'h3, 12'h400, 4'h0);
        instruccion = 4'h2;
        operando    = 4'h4;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst.inc", 12'(enabledCounter), 12'd1);
        reset = 1'b0;
        #1;
        checkOutput("midrst.acc0", 12'(acc),           12'h0);
        checkOutput("midrst.inc0", 12'(enabledCounter), 12'd0);
        checkOutput("midrst.ld0",  12'(loadCounter),    12'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst.acc1", 12'(acc), 12'h0);
        mAcc = 0; mOut = 0; mCarry = 0; mZero = 0;
        run   = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst.idle", 12'(enabled_fetch), 12'd0);
        checkOutput("midrst.acc2", 12'(acc),           12'h0);
        run = 1'b1;
        @(posedge clk);
        @(negedge clk);

        applyStimulus(4'h1, 4'h6, 12'h500, 4'h0);
        applyStimulus(4'hF, 4'h0, 12'h501, 4'h0);
        if (HALT_EN) begin
            for (int i = 0; i < 4; i++) begin
                run = ~run;
                @(negedge clk);
                checkOutput("halt.halted", 12'(halted),         12'd1);
                checkOutput("halt.inc",    12'(enabledCounter), 12'd0);
                checkOutput("halt.load",   12'(loadCounter),    12'd0);
                checkOutput("halt.fetch",  12'(enabled_fetch),  12'd0);
            end
        end else begin
            applyStimulus(4'h2, 4'h1, 12'h502, 4'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_execute.md
DECODE_EXECUTE -- requirements
Module: decode_execute

Interface
REQ-001 SHALL have parameter none; all widths fixed (4-bit datapath, 12-bit address).
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; clears all state immediately when 0.
REQ-004 run  input  1  start request; sampled in IDLE only.
REQ-005 instruccion  input  4  opcode from the fetch register; valid in EXEC.
REQ-006 operando  input  4  immediate/jump-low nibble from the fetch register; valid in EXEC.
REQ-007 pc  input  12  current program counter value.
REQ-008 data_in  input  4  external input port.
REQ-009 enabled_fetch  output  1  fetch-register enable.
REQ-010 enabledCounter  output  1  PC increment enable.
REQ-011 loadCounter  output  1  PC parallel-load strobe.
REQ-012 jump_addr  output  12  PC load value = {pc[11:4], operando}.
REQ-013 acc  output  4  accumulator; data_out  output  4  output-port register.
REQ-014 carry, zero  output  1 each  flags; halted  output  1  high in HALT.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, EXEC, HALT.
REQ-016 IDLE -> FETCH when run=1; else stay; FETCH -> EXEC unconditionally; EXEC -> FETCH unless opcode F (halt); HALT held until reset.
REQ-017 enabled_fetch SHALL be 1 only in FETCH (combinational from state).
REQ-018 In EXEC: loadCounter=1 iff jump taken; enabledCounter=1 iff not taken and not HALT opcode; both 0 in all other states; never both 1.
REQ-019 Opcodes: 0 NOP; 1 LIT A<=op; 2 ADD A<=A+op; 3 SUB A<=A-op; 4 AND; 5 OR; 6 XOR; 7 CMP (flags as SUB, A unchanged); 8 IN A<=data_in; 9 OUT data_out<=A; A JMP; B JC; C JNC; D JZ; E JNZ; F HALT.
REQ-020 Register writes (A, flags, data_out) SHALL occur on the clock edge ending EXEC; one instruction per 2 cycles.
REQ-021 ADD: 5-bit sum, A<=sum[3:0], carry<=sum[4]; wrap modulo 16.
REQ-022 SUB/CMP: carry<=1 when A>=op (no borrow), else 0; result modulo 16.
REQ-023 zero SHALL update on ops 1-8 to (result==0); carry only on 2,3,7; other ops leave flags.
REQ-024 Conditional jumps SHALL use flag values present during EXEC (before that edge's update, none occurs on jumps).
REQ-025 jump_addr SHALL stay within the current 16-word page; pc[3:0] ignored.
REQ-026 halted SHALL equal 1 exactly in HALT.

Reset
REQ-027 reset=0 SHALL force state IDLE, acc=0, data_out=0, carry=0, zero=0, all strobes 0, asynchronously, including mid-EXEC (no partial write).
REQ-028 After release, no activity until run=1 sampled in IDLE.

Configuration
REQ-029 Macro DECODE_HALT_EN: defined -> opcode F enters HALT (no PC increment); undefined -> opcode F decodes as NOP (PC increments), HALT unreachable, halted tied 0.

Verification
REQ-030 reset low mid-EXEC of ADD, A=3, op=4 -> acc=0, state IDLE, no strobes, acc never 7.
REQ-031 run=1; LIT 9 then ADD 9 -> acc=2, carry=1, zero=0; enabledCounter pulses once per EXEC, enabled_fetch once per FETCH.
REQ-032 LIT 5, CMP 5, JZ op=0xC with pc=0x123 -> zero=1, carry=1, acc=5; loadCounter=1, enabledCounter=0, jump_addr=0x12C.
REQ-033 LIT 2, SUB 3 then JC 4 -> acc=0xF, carry=0, jump not taken (enabledCounter=1, loadCounter=0).
REQ-034 data_in=0xA; IN, OUT -> acc=0xA, data_out=0xA, zero=0.
REQ-035 opcode F with DECODE_HALT_EN -> halted=1, strobes 0 forever, run ignored; without macro -> NOP, enabledCounter=1, FETCH next.
